// File: rtl/grng_pkg.sv
// Shared constants and types for the GRNG core's uniform (taus88) stage.
package grng_pkg;

  // Component masks that clear the low bits a Tausworthe component must not keep
  localparam logic [31:0] TAUS_MASK1 = 32'hFFFF_FFFE;
  localparam logic [31:0] TAUS_MASK2 = 32'hFFFF_FFF8;
  localparam logic [31:0] TAUS_MASK3 = 32'hFFFF_FFF0;

  // Shift triples per component: (left-xor, right, masked-left)
  localparam int unsigned TAUS_S1_A = 13;
  localparam int unsigned TAUS_S1_B = 19;
  localparam int unsigned TAUS_S1_C = 12;
  localparam int unsigned TAUS_S2_A = 2;
  localparam int unsigned TAUS_S2_B = 25;
  localparam int unsigned TAUS_S2_C = 4;
  localparam int unsigned TAUS_S3_A = 3;
  localparam int unsigned TAUS_S3_B = 11;
  localparam int unsigned TAUS_S3_C = 17;

  // Power-on seeds
  localparam logic [31:0] DEFAULT_SEED1 = 32'd12345;
  localparam logic [31:0] DEFAULT_SEED2 = 32'd67890;
  localparam logic [31:0] DEFAULT_SEED3 = 32'd13579;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } urng_state_e;

  // s1 is declared first so it occupies the top 32 bits of the packed 96-bit word
  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
  } taus_state_t;

  // Lift each component above its degenerate range (all-zero after masking)
  function automatic taus_state_t taus_fixup(input logic [95:0] seed);
    taus_state_t s;
    s = seed;
    if (s.s1 < 32'd2)  s.s1 = s.s1 + 32'd2;
    if (s.s2 < 32'd8)  s.s2 = s.s2 + 32'd8;
    if (s.s3 < 32'd16) s.s3 = s.s3 + 32'd16;
    return s;
  endfunction

endpackage

// File: rtl/taus_step.sv
// One taus88 state advance; purely combinational.
module taus_step
  import grng_pkg::*;
(
  input  taus_state_t state_i,
  output taus_state_t state_o
);

  // Apply the three independent component recurrences
  // NOTE: every output is assigned on every path, so no latch can be inferred.
  always_comb begin
    state_o.s1 = ((state_i.s1 & TAUS_MASK1) << TAUS_S1_C)
               ^ (((state_i.s1 << TAUS_S1_A) ^ state_i.s1) >> TAUS_S1_B);
    state_o.s2 = ((state_i.s2 & TAUS_MASK2) << TAUS_S2_C)
               ^ (((state_i.s2 << TAUS_S2_A) ^ state_i.s2) >> TAUS_S2_B);
    state_o.s3 = ((state_i.s3 & TAUS_MASK3) << TAUS_S3_C)
               ^ (((state_i.s3 << TAUS_S3_A) ^ state_i.s3) >> TAUS_S3_B);
  end

endmodule

// File: rtl/taus_urng.sv
// Combined three-component Tausworthe uniform RNG with valid/ready output,
// runtime reseeding and a discard-only warm-up after reset or reseed.
module taus_urng
  import grng_pkg::*;
#(
  parameter int unsigned WARMUP = 8,
  parameter logic [31:0] SEED1  = DEFAULT_SEED1,
  parameter logic [31:0] SEED2  = DEFAULT_SEED2,
  parameter logic [31:0] SEED3  = DEFAULT_SEED3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_valid,
  input  logic [95:0] seed,
  output logic        seed_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_value,
  output logic        warming
);

  localparam int unsigned           WCNT_W    = $clog2(WARMUP + 1);
  localparam logic [WCNT_W-1:0]     WCNT_LAST = WCNT_W'(WARMUP - 1);

  urng_state_e       fsm_q;
  logic [WCNT_W-1:0] wcnt_q;
  taus_state_t       taus_q;
  taus_state_t       taus_d;
  taus_state_t       seed_fixed;
  logic              out_valid_q;
  logic              warming_q;
  logic              seed_accept;

  // A new seed can be taken in any state
  assign seed_ready  = 1'b1;
  assign seed_accept = seed_valid && seed_ready;
  assign seed_fixed  = taus_fixup(seed);

  taus_step u_step (
    .state_i (taus_q),
    .state_o (taus_d)
  );

  // Output is the XOR of the live state, so a stall holds it bit-stable
  assign out_value = taus_q.s1 ^ taus_q.s2 ^ taus_q.s3;
  assign out_valid = out_valid_q;
  assign warming   = warming_q;

  // Warm-up / run sequencing, reseed handling and state advance
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  // NOTE: the generator state is a handful of flops, not a memory, so it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taus_q      <= taus_state_t'{s1: SEED1, s2: SEED2, s3: SEED3};
      fsm_q       <= ST_WARMUP;
      wcnt_q      <= '0;
      out_valid_q <= 1'b0;
      warming_q   <= 1'b1;
    end else if (seed_accept) begin
      // A seed load overrides any concurrent step; a same-edge transfer used the old word
      taus_q      <= seed_fixed;
      fsm_q       <= ST_WARMUP;
      wcnt_q      <= '0;
      out_valid_q <= 1'b0;
      warming_q   <= 1'b1;
    end else begin
      unique case (fsm_q)
        ST_WARMUP: begin
          taus_q <= taus_d;
          if (wcnt_q == WCNT_LAST) begin
            fsm_q       <= ST_RUN;
            wcnt_q      <= '0;
            out_valid_q <= 1'b1;
            warming_q   <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (out_valid_q && out_ready) begin
            taus_q <= taus_d;
          end
        end
        default: begin
          fsm_q       <= ST_WARMUP;
          wcnt_q      <= '0;
          out_valid_q <= 1'b0;
          warming_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
